// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Load/store data memory with byte strobes, req/ack handshake,
//            programmable access latency and misalign/range error response.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  localparam int         BYTES = DATA_W / 8;
  localparam int         OFF_W = $clog2(BYTES);
  localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BYTES-1:0]    be_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ack_q;
  logic                err_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                misaligned;
  logic                out_of_range;
  logic                fault;
  logic                do_write;
  logic [ADDR_W-1:0]   word_idx;
  logic [IDX_W-1:0]    mem_idx;

  if (OFF_W > 0) begin : g_align_chk
    assign misaligned = |addr_q[OFF_W-1:0];
  end else begin : g_no_align_chk
    assign misaligned = 1'b0;
  end

  assign word_idx     = addr_q >> OFF_W;
  assign mem_idx      = word_idx[IDX_W-1:0];
  // One extra bit keeps the compare exact when DEPTH == 2**ADDR_W.
  assign out_of_range = {1'b0, word_idx} >= (ADDR_W+1)'(DEPTH);
  assign fault        = misaligned | out_of_range;
  assign do_write     = (state_q == S_RESP) && we_q && !fault;

  // Array has no reset so contents survive an aborted access.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be_q[i]) begin
          mem_q[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        // The ack cycle is spent here with busy still high, so a request
        // presented then is taken on the edge that drops the ack.
        S_IDLE: begin
          busy_q <= req;
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            cnt_q   <= LAT_C;
            state_q <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          ack_q <= 1'b1;
          err_q <= fault;
          if (!we_q && !fault) begin
            rdata_q <= mem_q[mem_idx];
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Scoreboard bench over four latency/depth configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  function automatic int lat_f(input int g);
    case (g)
      0: return 1;
      1: return 0;
      2: return 15;
      default: return 3;
    endcase
  endfunction

  function automatic int dep_f(input int g);
    case (g)
      0: return 1024;
      1: return 16;
      2: return 16;
      default: return 64;
    endcase
  endfunction

  typedef struct {
    int          k;
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_s;
  logic [3:0]  we_s;
  logic [31:0] addr_s [4];
  logic [31:0] wd_s   [4];
  logic [3:0]  be_s   [4];
  logic [31:0] rd_s   [4];
  logic [3:0]  ack_s;
  logic [3:0]  err_s;
  logic [3:0]  busy_s;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_ctrl #(
      .DATA_W (32),
      .ADDR_W (32),
      .DEPTH  (dep_f(g)),
      .LATENCY(lat_f(g))
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req_s[g]),
      .we   (we_s[g]),
      .addr (addr_s[g]),
      .wdata(wd_s[g]),
      .be   (be_s[g]),
      .rdata(rd_s[g]),
      .ack  (ack_s[g]),
      .err  (err_s[g]),
      .busy (busy_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, expv);
    end
  endtask

  // Every ack pops one expectation: instance, arrival cycle, err, rdata.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (ack_s[k] === 1'b1) begin
        if (sbq.size() == 0) begin
          check("spurious_ack", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          check("ack_inst", 32'(k), 32'(e.k));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          check("ack_err", {31'b0, err_s[k]}, {31'b0, e.err});
          check("rdata", rd_s[k], e.rd);
        end
      end
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 64 && sbq.size() != 0; i++) @(negedge clk);
    check("ack_timeout", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic acc(input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b,
                     input logic e_err, input logic [31:0] e_rd);
    @(negedge clk);
    req_s[k]  = 1'b1;
    we_s[k]   = w;
    addr_s[k] = a;
    wd_s[k]   = wd;
    be_s[k]   = b;
    sbq.push_back(exp_t'{k, cyc + lat_f(k) + 2, e_err, e_rd});
    @(negedge clk);
    req_s[k]  = 1'b0;
    addr_s[k] = 32'hFFFF_FFFF;
    check("busy_after_accept", {31'b0, busy_s[k]}, 32'd1);
    wait_empty();
  endtask

  // req held high: one acceptance per LATENCY+2 cycles, reading 0, 4, 8.
  task automatic btb(input int k, input logic [31:0] base);
    int lat;
    lat = lat_f(k);
    @(negedge clk);
    req_s[k] = 1'b1;
    we_s[k]  = 1'b0;
    be_s[k]  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      addr_s[k] = 32'(4 * i);
      sbq.push_back(exp_t'{k, cyc + lat + 2, 1'b0, base + 32'(i)});
      repeat (lat + 2) @(negedge clk);
    end
    req_s[k] = 1'b0;
    wait_empty();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst    = 1'b1;
    req_s  = 4'h0;
    we_s   = 4'h0;
    for (int k = 0; k < 4; k++) begin
      addr_s[k] = '0;
      wd_s[k]   = '0;
      be_s[k]   = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_ack",   {31'b0, ack_s[k]},  32'd0);
      check("rst_err",   {31'b0, err_s[k]},  32'd0);
      check("rst_busy",  {31'b0, busy_s[k]}, 32'd0);
      check("rst_rdata", rd_s[k],            32'd0);
    end

    // LATENCY=1, DEPTH=1024: basic access, byte lanes, faults.
    acc(0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    acc(0, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 32'hDEADBEEF);
    acc(0, 1'b1, 32'h10,   32'h11223344, 4'h5, 1'b0, 32'hDEADBEEF);
    acc(0, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 32'hDE22BE44);
    acc(0, 1'b1, 32'h12,   32'h0BADF00D, 4'hF, 1'b1, 32'hDE22BE44);
    acc(0, 1'b1, 32'h1000, 32'h0BADF00D, 4'hF, 1'b1, 32'hDE22BE44);
    acc(0, 1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 1'b0, 32'hDE22BE44);
    acc(0, 1'b0, 32'h11,   32'h0,        4'h0, 1'b1, 32'hDE22BE44);
    acc(0, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 32'hDE22BE44);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdata", rd_s[0], 32'd0);
    check("async_rst_ack",   {31'b0, ack_s[0]},  32'd0);
    check("async_rst_err",   {31'b0, err_s[0]},  32'd0);
    check("async_rst_busy",  {31'b0, busy_s[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=0 and LATENCY=15 at DEPTH=16.
    for (int k = 1; k <= 2; k++) begin
      logic [31:0] base;
      base = (k == 1) ? 32'hA000_0000 : 32'hB000_0000;
      for (int i = 0; i < 3; i++) begin
        acc(k, 1'b1, 32'(4 * i), base + 32'(i), 4'hF, 1'b0, 32'h0);
      end
      btb(k, base);
      acc(k, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, base + 32'd2);
    end

    // LATENCY=3: reset two cycles into a write discards it.
    acc(3, 1'b1, 32'h24, 32'h55, 4'hF, 1'b0, 32'h0);
    acc(3, 1'b1, 32'h20, 32'h0,  4'hF, 1'b0, 32'h0);
    acc(3, 1'b0, 32'h24, 32'h0,  4'h0, 1'b0, 32'h55);
    @(negedge clk);
    req_s[3]  = 1'b1;
    we_s[3]   = 1'b1;
    addr_s[3] = 32'h20;
    wd_s[3]   = 32'hCAFEF00D;
    be_s[3]   = 4'hF;
    @(negedge clk);
    req_s[3]  = 1'b0;
    check("abort_busy_before", {31'b0, busy_s[3]}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy_rst",  {31'b0, busy_s[3]}, 32'd0);
    check("abort_rdata_rst", rd_s[3], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_ack", {31'b0, ack_s[3]}, 32'd0);
    end
    acc(3, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 32'h55);
    acc(3, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
